// File: rtl/reg_window_spill_fill_if.sv
// Bundle of the decode handshake, register-file port and data-memory port
// seen by the register window manager.
interface reg_window_spill_fill_if #(
  parameter int DATA_W = 16
);
  // Decode handshake
  logic              call_req;
  logic              ret_req;
  logic              busy;
  logic              done;
  logic              err;
  // Register-file port
  logic [1:0]        wind;
  logic [2:0]        rf_raddr;
  logic [DATA_W-1:0] rf_rdata;
  logic [2:0]        rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              rf_we;
  // Data-memory port
  logic              mem_req;
  logic              mem_we;
  logic [15:0]       mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  // Window manager side
  modport slave (
    input  call_req, ret_req, rf_rdata, mem_rdata, mem_ack,
    output busy, done, err, wind, rf_raddr, rf_waddr, rf_wdata, rf_we,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  // Decode / register file / memory side
  modport master (
    output call_req, ret_req, rf_rdata, mem_rdata, mem_ack,
    input  busy, done, err, wind, rf_raddr, rf_waddr, rf_wdata, rf_we,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/reg_window_spill_fill.sv
// Register window manager: tracks the current window pointer, serves
// call/return from decode, spills the oldest resident window to a downward
// growing memory stack when the file is full and fills it back on underflow.
module reg_window_spill_fill #(
  parameter int          DATA_W     = 16,
  parameter int          NWIN       = 4,
  parameter int          SPILL_REGS = 2,
  parameter logic [15:0] STACK_BASE = 16'hFF00
) (
  input logic                    clk,
  input logic                    rst,
  reg_window_spill_fill_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SPILL_RD,
    S_SPILL_WR,
    S_FILL_REQ,
    S_FILL_WR,
    S_DONE
  } state_t;

  localparam logic [1:0]  OCC_MAX = 2'(NWIN - 1);
  localparam logic [1:0]  WIN_MAX = 2'(NWIN - 1);
  localparam logic [2:0]  K_LAST  = 3'(SPILL_REGS - 1);
  localparam logic [15:0] SP_STEP = 16'(SPILL_REGS);

  state_t            state_q, state_d;
  logic [1:0]        cwp_q, cwp_d;
  logic [1:0]        occ_q, occ_d;
  logic [7:0]        scnt_q, scnt_d;
  logic [15:0]       sp_q, sp_d;
  logic [2:0]        k_q, k_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              fill_q, fill_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  // Window indices wrap modulo NWIN, which need not fill the 2-bit field.
  function automatic logic [1:0] win_next(input logic [1:0] w);
    return (w == WIN_MAX) ? 2'd0 : w + 2'd1;
  endfunction

  function automatic logic [1:0] win_prev(input logic [1:0] w);
    return (w == 2'd0) ? WIN_MAX : w - 2'd1;
  endfunction

  // State register; reset abandons any in-flight transfer immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cwp_q   <= 2'd0;
      occ_q   <= 2'd0;
      scnt_q  <= 8'd0;
      sp_q    <= STACK_BASE;
      k_q     <= 3'd0;
      data_q  <= '0;
      fill_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cwp_q   <= cwp_d;
      occ_q   <= occ_d;
      scnt_q  <= scnt_d;
      sp_q    <= sp_d;
      k_q     <= k_d;
      data_q  <= data_d;
      fill_q  <= fill_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: request decode in IDLE, per-register spill/fill sequencing,
  // and the pointer/stack bookkeeping committed in DONE.
  always_comb begin
    state_d = state_q;
    cwp_d   = cwp_q;
    occ_d   = occ_q;
    scnt_d  = scnt_q;
    sp_d    = sp_q;
    k_d     = k_q;
    data_d  = data_q;
    fill_d  = fill_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.call_req && bus.ret_req) begin
          err_d = 1'b1;
        end else if (bus.call_req) begin
          if (occ_q < OCC_MAX) begin
            cwp_d  = win_next(cwp_q);
            occ_d  = occ_q + 2'd1;
            done_d = 1'b1;
          end else if (scnt_q != 8'hFF) begin
            state_d = S_SPILL_RD;
            k_d     = 3'd0;
            fill_d  = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end else if (bus.ret_req) begin
          if (occ_q != 2'd0) begin
            cwp_d  = win_prev(cwp_q);
            occ_d  = occ_q - 2'd1;
            done_d = 1'b1;
          end else if (scnt_q != 8'd0) begin
            // Registers come back in reverse order of the spill.
            state_d = S_FILL_REQ;
            k_d     = K_LAST;
            fill_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_SPILL_RD: begin
        data_d  = bus.rf_rdata;
        state_d = S_SPILL_WR;
      end
      S_SPILL_WR: begin
        if (bus.mem_ack) begin
          if (k_q == K_LAST) begin
            state_d = S_DONE;
          end else begin
            k_d     = k_q + 3'd1;
            state_d = S_SPILL_RD;
          end
        end
      end
      S_FILL_REQ: begin
        if (bus.mem_ack) begin
          data_d  = bus.mem_rdata;
          state_d = S_FILL_WR;
        end
      end
      S_FILL_WR: begin
        if (k_q == 3'd0) begin
          state_d = S_DONE;
        end else begin
          k_d     = k_q - 3'd1;
          state_d = S_FILL_REQ;
        end
      end
      S_DONE: begin
        // A spill keeps occupancy: the victim slot becomes the new window.
        if (fill_q) begin
          sp_d   = sp_q + SP_STEP;
          scnt_d = scnt_q - 8'd1;
          cwp_d  = win_prev(cwp_q);
        end else begin
          sp_d   = sp_q - SP_STEP;
          scnt_d = scnt_q + 8'd1;
          cwp_d  = win_next(cwp_q);
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Port drive: everything idles at zero except wind, which shows cwp unless
  // a transfer is addressing the victim or target window.
  always_comb begin
    bus.busy      = (state_q != S_IDLE);
    bus.done      = done_q | (state_q == S_DONE);
    bus.err       = err_q;
    bus.wind      = cwp_q;
    bus.rf_raddr  = 3'd0;
    bus.rf_waddr  = 3'd0;
    bus.rf_wdata  = '0;
    bus.rf_we     = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = 16'd0;
    bus.mem_wdata = '0;
    case (state_q)
      S_SPILL_RD: begin
        bus.wind     = win_next(cwp_q);
        bus.rf_raddr = k_q;
      end
      S_SPILL_WR: begin
        bus.wind      = win_next(cwp_q);
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = sp_q - 16'd1 - {13'd0, k_q};
        bus.mem_wdata = data_q;
      end
      S_FILL_REQ: begin
        bus.wind     = win_prev(cwp_q);
        bus.mem_req  = 1'b1;
        bus.mem_addr = sp_q + {13'd0, K_LAST - k_q};
      end
      S_FILL_WR: begin
        bus.wind     = win_prev(cwp_q);
        bus.rf_waddr = k_q;
        bus.rf_wdata = data_q;
        bus.rf_we    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_reg_window_spill_fill.sv
// Bench for the register window manager: a register file and a latency
// programmable memory surround the DUT; an abstract window-stack model
// predicts pointer movement, stack traffic and restored register contents.
module tb_reg_window_spill_fill;
  localparam int DATA_W = 16;
  localparam int NWIN   = 4;
  localparam int SR     = 2;

  typedef logic [SR-1:0][15:0] win_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  reg_window_spill_fill_if #(.DATA_W(DATA_W)) bus ();

  reg_window_spill_fill #(
    .DATA_W(DATA_W), .NWIN(NWIN), .SPILL_REGS(SR), .STACK_BASE(16'hFF00)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [15:0] rf  [NWIN][8];
  logic [15:0] mem [0:65535];

  assign bus.rf_rdata = rf[bus.wind][bus.rf_raddr];

  int n_tests = 0;
  int n_fail  = 0;
  int mem_lat = 0;
  int wait_cnt = 0;
  int n_mem_ops = 0;
  logic [15:0] wr_log[$];
  logic [15:0] rd_log[$];

  int          m_cwp, m_occ, m_scnt;
  logic [15:0] m_sp;
  win_t        m_stack[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Environment: memory responder and register-file write port, evaluated
  // once per cycle just after the rising edge.
  task automatic env_step();
    if (!rst) begin
      bus.mem_ack = 1'b0;
      wait_cnt = 0;
      return;
    end
    if (bus.rf_we) rf[bus.wind][bus.rf_waddr] = bus.rf_wdata;
    if (bus.mem_ack) begin
      bus.mem_ack = 1'b0;
    end else if (bus.mem_req) begin
      if (wait_cnt >= mem_lat) begin
        bus.mem_ack = 1'b1;
        wait_cnt = 0;
        n_mem_ops++;
        if (bus.mem_we) begin
          wr_log.push_back(bus.mem_addr);
          mem[bus.mem_addr] = bus.mem_wdata;
        end else begin
          rd_log.push_back(bus.mem_addr);
          bus.mem_rdata = mem[bus.mem_addr];
        end
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    env_step();
  endtask

  task automatic model_reset();
    m_cwp = 0; m_occ = 0; m_scnt = 0; m_sp = 16'hFF00;
    m_stack.delete();
  endtask

  task automatic do_reset();
    bus.call_req = 1'b0;
    bus.ret_req  = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    model_reset();
    tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_wind", bus.wind, 0);
    chk("rst_mem_req", bus.mem_req, 0);
  endtask

  // One decode request, checked end to end against the model.
  task automatic op(input bit c, input bit r, input bit scramble, input bit poke);
    int kind, victim, target, n, ops0, extra_done;
    bit seen;
    win_t save, got;
    // 0 quick call, 1 quick return, 2 spill, 3 fill, 4 error
    if (c && r) kind = 4;
    else if (c) kind = (m_occ < NWIN-1) ? 0 : (m_scnt < 255) ? 2 : 4;
    else kind = (m_occ > 0) ? 1 : (m_scnt > 0) ? 3 : 4;
    victim = (m_cwp + 1) % NWIN;
    target = (m_cwp + NWIN - 1) % NWIN;
    for (int k = 0; k < SR; k++) begin
      if (kind == 2 && scramble) rf[victim][k] = 16'($urandom);
      if (kind == 3) rf[target][k] = 16'($urandom);
      save[k] = rf[victim][k];
    end
    wr_log.delete();
    rd_log.delete();
    ops0 = n_mem_ops;
    bus.call_req = c;
    bus.ret_req  = r;
    tick();
    bus.call_req = 1'b0;
    bus.ret_req  = 1'b0;
    if (kind == 0 || kind == 1) begin
      m_cwp = (kind == 0) ? (m_cwp + 1) % NWIN : (m_cwp + NWIN - 1) % NWIN;
      m_occ = (kind == 0) ? m_occ + 1 : m_occ - 1;
      chk("quick_done", bus.done, 1);
      chk("quick_err", bus.err, 0);
      chk("quick_busy", bus.busy, 0);
      chk("quick_wind", bus.wind, 32'(m_cwp));
    end else if (kind == 4) begin
      chk("err_pulse", bus.err, 1);
      chk("err_done", bus.done, 0);
      chk("err_busy", bus.busy, 0);
      chk("err_wind", bus.wind, 32'(m_cwp));
    end else begin
      chk("xfer_busy", bus.busy, 1);
      chk("xfer_early_done", bus.done, 0);
      seen = 1'b0;
      for (n = 1; n <= 400; n++) begin
        tick();
        if (bus.done) begin
          bus.call_req = 1'b0;
          seen = 1'b1;
          break;
        end
        bus.call_req = poke && (n == 1);
      end
      bus.call_req = 1'b0;
      chk("xfer_done_seen", seen, 1);
      chk("xfer_cycles", n, SR * (2 + mem_lat));
      chk("xfer_done_busy", bus.busy, 1);
      chk("xfer_done_wind", bus.wind, 32'(m_cwp));
      tick();
      chk("xfer_mem_ops", n_mem_ops - ops0, SR);
      if (kind == 2) begin
        chk("spill_nwr", wr_log.size(), SR);
        for (int k = 0; k < SR; k++) begin
          logic [15:0] a;
          a = m_sp - 16'd1 - 16'(k);
          if (k < wr_log.size()) chk($sformatf("spill_addr[%0d]", k), wr_log[k], a);
          chk($sformatf("spill_data[%0d]", k), mem[a], save[k]);
        end
        m_stack.push_back(save);
        m_sp = m_sp - 16'(SR);
        m_scnt++;
        m_cwp = victim;
      end else begin
        got = m_stack.pop_back();
        chk("fill_nrd", rd_log.size(), SR);
        for (int i = 0; i < SR; i++) begin
          if (i < rd_log.size()) chk($sformatf("fill_addr[%0d]", i), rd_log[i], m_sp + 16'(i));
          chk($sformatf("fill_data[%0d]", i), rf[target][i], got[i]);
        end
        m_sp = m_sp + 16'(SR);
        m_scnt--;
        m_cwp = target;
      end
      chk("xfer_end_busy", bus.busy, 0);
      chk("xfer_end_wind", bus.wind, 32'(m_cwp));
    end
    tick();
    chk("idle_done", bus.done, 0);
    chk("idle_err", bus.err, 0);
    chk("idle_busy", bus.busy, 0);
    chk("idle_wind", bus.wind, 32'(m_cwp));
    if (kind < 2 || kind == 4) chk("no_mem_traffic", n_mem_ops - ops0, 0);
    if (poke) begin
      extra_done = 0;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (bus.done || bus.busy) extra_done++;
      end
      chk("poke_single_xfer", extra_done, 0);
      chk("poke_mem_ops", n_mem_ops - ops0, SR);
    end
  endtask

  initial begin
    int sel;
    bit seen;
    bus.call_req  = 1'b0;
    bus.ret_req   = 1'b0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    for (int w = 0; w < NWIN; w++)
      for (int i = 0; i < 8; i++) rf[w][i] = 16'($urandom);
    model_reset();

    // Reset state, then reset in the middle of a spill
    do_reset();
    mem_lat = 3;
    repeat (3) op(1'b1, 1'b0, 1'b0, 1'b0);
    bus.call_req = 1'b1;
    tick();
    bus.call_req = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.mem_req) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    chk("t1_mem_req_seen", seen, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("t1_mem_req_drop", bus.mem_req, 0);
    chk("t1_busy_drop", bus.busy, 0);
    chk("t1_wind_drop", bus.wind, 0);
    chk("t1_done_drop", bus.done, 0);
    tick();
    tick();
    rst = 1'b1;
    model_reset();
    tick();

    // Three calls from reset, then a spill of window 0
    mem_lat = 1;
    repeat (3) op(1'b1, 1'b0, 1'b0, 1'b0);
    rf[0][0] = 16'hAAAA;
    rf[0][1] = 16'h5555;
    mem_lat = 2;
    op(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t3_mem_feff", mem[16'hFEFF], 16'hAAAA);
    chk("t3_mem_fefe", mem[16'hFEFE], 16'h5555);
    chk("t3_wind", bus.wind, 0);

    // Four returns, the last one refilling the spilled window
    mem_lat = 1;
    repeat (4) op(1'b0, 1'b1, 1'b0, 1'b0);
    chk("t4_reg1", rf[0][1], 16'h5555);
    chk("t4_reg0", rf[0][0], 16'hAAAA);

    // Underflow and simultaneous requests from reset state
    do_reset();
    op(1'b0, 1'b1, 1'b0, 1'b0);
    op(1'b1, 1'b1, 1'b0, 1'b0);

    // Call pulsed while a spill is in progress
    repeat (3) op(1'b1, 1'b0, 1'b0, 1'b0);
    mem_lat = 2;
    op(1'b1, 1'b0, 1'b1, 1'b1);

    // Randomized mix of calls, returns and collisions
    do_reset();
    for (int i = 0; i < 150; i++) begin
      mem_lat = $urandom_range(0, 3);
      sel = $urandom_range(0, 9);
      if (sel == 0) op(1'b1, 1'b1, 1'b1, 1'b0);
      else if (sel <= 5) op(1'b1, 1'b0, 1'b1, 1'b0);
      else op(1'b0, 1'b1, 1'b1, 1'b0);
    end

    // Spill-count saturation
    do_reset();
    mem_lat = 0;
    repeat (3) op(1'b1, 1'b0, 1'b1, 1'b0);
    repeat (255) op(1'b1, 1'b0, 1'b1, 1'b0);
    op(1'b1, 1'b0, 1'b1, 1'b0);
    op(1'b0, 1'b1, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
